garage_door_ctrl: RTL and testbench
===================================

Name: garage_door_ctrl

Overview:
Garage door controller FSM. It sits directly downstream of the button synchronizer and consumes that stage's one-cycle press pulse. It combines the pulse with the limit-switch and safety-beam inputs to drive the up/down motor, the courtesy light and a fault flag. The FSM is Moore: outputs decode registered state and counters only.

Parameters:
TRAVEL_MAX, 1500, maximum cycles allowed in OPENING/CLOSING before FAULT; must be ≥ 2.
LIGHT_HOLD, 500, cycles Light stays on after motion stops; must be ≥ 1.
AUTO_CLOSE, 3000, cycles in OPEN before automatic close; used only when AUTO_CLOSE_EN is defined; must be ≥ 1.

Ports:
Clk  in  1  system clock, all logic posedge
Rst_n  in  1  synchronous active-low reset
Bp  in  1  one-cycle press pulse from the button synchronizer, already synchronous
LimOpen  in  1  door-fully-open limit switch, synchronous, active-high
LimClosed  in  1  door-fully-closed limit switch, synchronous, active-high
Obstruct  in  1  safety beam broken, synchronous, active-high
MotorUp  out  1  drive motor upward
MotorDn  out  1  drive motor downward
Light  out  1  courtesy light
Fault  out  1  FAULT state indicator
DoorState  out  3  current state encoding (package enum)

Behaviour:
- One clock, Clk. Reset is synchronous and active-low (Rst_n sampled on posedge Clk).
- Reset: State=STOPPED, LastDir=DN, TravelCnt=0, LightCnt=0, Light=0. Resulting outputs: MotorUp=0, MotorDn=0, Fault=0.
- Reset mid-motion: motors are off in the first cycle after the reset edge.
- States: CLOSED, OPENING, OPEN, CLOSING, STOPPED, FAULT.
- Motor decode:
  - MotorUp = (State==OPENING); MotorDn = (State==CLOSING).
  - Both motor outputs are never 1 simultaneously.
- Latency: Bp high in cycle n → the new state and motor output are visible in cycle n+1.
- Global rule: LimOpen && LimClosed in any non-FAULT state → FAULT next cycle. This has highest priority.
- Per-state transitions, listed in priority order:
  - CLOSED: Bp → OPENING.
  - OPENING: LimOpen → OPEN; TravelCnt==TRAVEL_MAX-1 → FAULT; Bp → STOPPED with LastDir=UP. Obstruct is ignored.
  - OPEN: Bp && !Obstruct → CLOSING. Bp while Obstruct=1 is dropped and the state stays OPEN.
  - CLOSING: Obstruct → OPENING (reversal); LimClosed → CLOSED; timeout → FAULT; Bp → STOPPED with LastDir=DN.
  - STOPPED: LimClosed → CLOSED; LimOpen → OPEN; Bp with LastDir=UP and !Obstruct → CLOSING; Bp with LastDir=DN → OPENING. Otherwise the state holds.
  - FAULT: absorbing; exits only via Rst_n.
- TravelCnt:
  - Cleared on every entry to OPENING or CLOSING, including a reversal.
  - Increments each cycle while in either of those states; zero elsewhere.
  - Width is $clog2(TRAVEL_MAX).
- Light:
  - Light=1 while in OPENING or CLOSING.
  - On the cycle motion ends, LightCnt loads LIGHT_HOLD and decrements each cycle; Light=1 while LightCnt≠0.
  - A new motion cancels the hold.
  - Entering FAULT forces Light=0 and LightCnt=0.
- Bp pulse simultaneous with a limit switch: the limit switch wins, and the pulse is consumed with no effect.

Optional Feature:
Macro AUTO_CLOSE_EN.
- Defined:
  - AutoCnt clears on entry to OPEN and increments while in OPEN.
  - Any Bp or Obstruct in OPEN reclears it.
  - When AutoCnt reaches AUTO_CLOSE-1 with Obstruct=0, the FSM goes to CLOSING.
  - If Obstruct=1 at expiry, AutoCnt saturates and the FSM waits for Obstruct=0, then closes the following cycle.
- Not defined: AutoCnt and its logic are absent; OPEN leaves only via Bp or the global fault rule.

Decomposition:
- Package garage_pkg holds:
  - state_t: 3-bit enum with CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, STOPPED=4, FAULT=5.
  - dir_t: UP/DN.
- Sub-module cycle_timer: generic load/clear/increment counter with parameterised width and terminal-count flag. It is instantiated for TravelCnt, LightCnt and (conditionally) AutoCnt.

Test Plan (TRAVEL_MAX=20, LIGHT_HOLD=8, AUTO_CLOSE=30):
1. Reset, LimClosed=1, then Bp at cycle 5 → DoorState CLOSED by cycle 2; MotorUp=1 from cycle 6. Raise LimOpen at cycle 12 → OPEN at 13, motors 0, Light=1 through cycle 20, Light=0 at 21.
2. From OPEN, Bp → CLOSING; Obstruct pulse 3 cycles later → OPENING next cycle, MotorDn=0 and MotorUp=1 in that same cycle, TravelCnt restarted at 0.
3. CLOSING with no limit switch for 20 cycles → FAULT, Fault=1, motors 0, Light=0. Further Bp is ignored; Rst_n=0 for one edge → STOPPED.
4. OPENING, Bp → STOPPED; Bp → CLOSING; Bp → STOPPED; Bp → OPENING (LastDir alternation verified). In OPEN with Obstruct=1, Bp → stays OPEN.
5. LimOpen=LimClosed=1 asserted while in OPEN → FAULT in the next cycle.
6. With AUTO_CLOSE_EN: OPEN idle for 30 cycles → CLOSING on cycle 30. Repeat with Obstruct=1 at expiry → holds OPEN; Obstruct drops → CLOSING the next cycle.

Source files
------------

// File: rtl/garage_pkg.sv
// Shared types and helpers for the garage door controller.
//   state_t : door FSM state encoding, also driven out on DoorState
//   dir_t   : last travel direction, remembered across a manual stop
//   cnt_width()  : counter width for a modulus, never narrower than 1 bit
//   in_motion()  : true for the two motor-driven states
package garage_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    STOPPED = 3'd4,
    FAULT   = 3'd5
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic in_motion(input state_t s);
    return (s == OPENING) || (s == CLOSING);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Generic cycle counter with synchronous clear, parallel load and
// count-enable, counting up or down (DOWN parameter).
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   clr        : force count to zero (highest priority)
//   load       : load load_val (beats en)
//   load_val   : value for load
//   en         : step the count by one
//   tc         : count currently equals TC_VAL
module cycle_timer #(
  parameter int unsigned    W      = 8,
  parameter logic [W-1:0]   TC_VAL = '0,
  parameter bit             DOWN   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = DOWN ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/garage_door_ctrl.sv
// Garage door controller: Moore FSM driven by the synchronised one-cycle
// button pulse, the two limit switches and the safety beam.
//   Clk, Rst_n            : clock, synchronous active-low reset
//   Bp                    : one-cycle press pulse
//   LimOpen, LimClosed    : fully-open / fully-closed limit switches
//   Obstruct              : safety beam broken
//   MotorUp, MotorDn      : motor drive (never both high)
//   Light                 : courtesy light, held LIGHT_HOLD cycles after motion
//   Fault                 : FAULT state indicator
//   DoorState             : current state_t encoding
// Optional feature: define AUTO_CLOSE_EN to close automatically after
// AUTO_CLOSE idle cycles in OPEN.
module garage_door_ctrl
  import garage_pkg::*;
#(
  parameter int unsigned TRAVEL_MAX = 1500,
  parameter int unsigned LIGHT_HOLD = 500,
  parameter int unsigned AUTO_CLOSE = 3000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Bp,
  input  logic       LimOpen,
  input  logic       LimClosed,
  input  logic       Obstruct,
  output logic       MotorUp,
  output logic       MotorDn,
  output logic       Light,
  output logic       Fault,
  output logic [2:0] DoorState
);

  localparam int unsigned TW = cnt_width(TRAVEL_MAX);
  localparam int unsigned LW = cnt_width(LIGHT_HOLD + 1);

  if (TRAVEL_MAX < 2) begin : g_bad_travel
    $error("TRAVEL_MAX must be at least 2");
  end
  if (LIGHT_HOLD < 1) begin : g_bad_light
    $error("LIGHT_HOLD must be at least 1");
  end
  if (AUTO_CLOSE < 1) begin : g_bad_auto
    $error("AUTO_CLOSE must be at least 1");
  end

  state_t state_q, state_d;
  dir_t   last_dir_q, last_dir_d;

  logic travel_tc;
  logic light_zero;
  logic motion_now;
  logic motion_next;
  logic travel_clr;
  logic light_clr;
`ifdef AUTO_CLOSE_EN
  logic auto_tc;
  logic auto_clr;
  logic auto_en;
`endif

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    if (LimOpen && LimClosed && (state_q != FAULT)) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        CLOSED: begin
          if (Bp) state_d = OPENING;
        end
        OPENING: begin
          if (LimOpen) begin
            state_d = OPEN;
          end else if (travel_tc) begin
            state_d = FAULT;
          end else if (Bp) begin
            state_d    = STOPPED;
            last_dir_d = UP;
          end
        end
        OPEN: begin
          if (Bp && !Obstruct) begin
            state_d = CLOSING;
          end
`ifdef AUTO_CLOSE_EN
          else if (auto_tc && !Obstruct) begin
            state_d = CLOSING;
          end
`endif
        end
        CLOSING: begin
          if (Obstruct) begin
            state_d = OPENING;
          end else if (LimClosed) begin
            state_d = CLOSED;
          end else if (travel_tc) begin
            state_d = FAULT;
          end else if (Bp) begin
            state_d    = STOPPED;
            last_dir_d = DN;
          end
        end
        STOPPED: begin
          if (LimClosed) begin
            state_d = CLOSED;
          end else if (LimOpen) begin
            state_d = OPEN;
          end else if (Bp && (last_dir_q == UP) && !Obstruct) begin
            state_d = CLOSING;
          end else if (Bp && (last_dir_q == DN)) begin
            state_d = OPENING;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= STOPPED;
      last_dir_q <= DN;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign motion_now  = in_motion(state_q);
  assign motion_next = in_motion(state_d);

  // A change of state into motion (including a reversal) restarts travel time.
  assign travel_clr = !motion_next || (state_d != state_q);

  cycle_timer #(
    .W      (TW),
    .TC_VAL (TW'(TRAVEL_MAX - 1)),
    .DOWN   (1'b0)
  ) u_travel (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (travel_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (motion_next),
    .tc       (travel_tc)
  );

  // Hold is loaded on the cycle motion stops; any motion or a fault wipes it.
  assign light_clr = (state_d == FAULT) || motion_next;

  cycle_timer #(
    .W      (LW),
    .TC_VAL ('0),
    .DOWN   (1'b1)
  ) u_light (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (light_clr),
    .load     (motion_now),
    .load_val (LW'(LIGHT_HOLD)),
    .en       (!light_zero),
    .tc       (light_zero)
  );

`ifdef AUTO_CLOSE_EN
  localparam int unsigned AW = cnt_width(AUTO_CLOSE);

  // Once expired the count saturates so a late obstruction only delays the close.
  assign auto_clr = (state_q != OPEN) || (!auto_tc && (Bp || Obstruct));
  assign auto_en  = (state_q == OPEN) && !auto_tc;

  cycle_timer #(
    .W      (AW),
    .TC_VAL (AW'(AUTO_CLOSE - 1)),
    .DOWN   (1'b0)
  ) u_auto (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (auto_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (auto_en),
    .tc       (auto_tc)
  );
`endif

  assign MotorUp   = (state_q == OPENING);
  assign MotorDn   = (state_q == CLOSING);
  assign Light     = motion_now || !light_zero;
  assign Fault     = (state_q == FAULT);
  assign DoorState = state_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Directed bench for garage_door_ctrl with TRAVEL_MAX=20, LIGHT_HOLD=8,
// AUTO_CLOSE=30. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_garage_door_ctrl;
  import garage_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Bp;
  logic       LimOpen;
  logic       LimClosed;
  logic       Obstruct;
  logic       MotorUp;
  logic       MotorDn;
  logic       Light;
  logic       Fault;
  logic [2:0] DoorState;

  int total = 0;
  int bad   = 0;

  garage_door_ctrl #(
    .TRAVEL_MAX (20),
    .LIGHT_HOLD (8),
    .AUTO_CLOSE (30)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Bp        (Bp),
    .LimOpen   (LimOpen),
    .LimClosed (LimClosed),
    .Obstruct  (Obstruct),
    .MotorUp   (MotorUp),
    .MotorDn   (MotorDn),
    .Light     (Light),
    .Fault     (Fault),
    .DoorState (DoorState)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    Bp = 1'b1;
    tick();
    Bp = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(DoorState), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic up, input logic dn,
                         input logic lt, input logic ft);
    chk($sformatf("%s.up", tag), 32'(MotorUp), 32'(up));
    chk($sformatf("%s.dn", tag), 32'(MotorDn), 32'(dn));
    chk($sformatf("%s.light", tag), 32'(Light), 32'(lt));
    chk($sformatf("%s.fault", tag), 32'(Fault), 32'(ft));
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; Bp = 1'b0; LimOpen = 1'b0; LimClosed = 1'b1; Obstruct = 1'b0;

    // 1: reset, close via limit, open, light hold after motion stops
    tick();
    chk_st("rst_state", STOPPED);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    tick();
    chk_st("closed_by_limit", CLOSED);
    press();
    LimClosed = 1'b0;
    chk_st("bp_opening", OPENING);
    chk_out("opening", 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(5);
    chk_st("still_opening", OPENING);
    LimOpen = 1'b1;
    tick();
    chk_st("open_at_limit", OPEN);
    chk_out("open", 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(7);
    chk("light_hold_last", 32'(Light), 32'd1);
    tick();
    chk("light_hold_done", 32'(Light), 32'd0);

    // 2: close, obstruction reverses, travel time restarts on reversal
    press();
    LimOpen = 1'b0;
    chk_st("bp_closing", CLOSING);
    chk_out("closing", 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(2);
    Obstruct = 1'b1;
    tick();
    Obstruct = 1'b0;
    chk_st("reversal", OPENING);
    chk_out("reversal", 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(19);
    chk_st("opening_cycle20", OPENING);
    tick();
    chk_st("opening_timeout", FAULT);
    chk_out("open_to", 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk_st("reset_from_fault", STOPPED);
    chk("fault_cleared", 32'(Fault), 32'd0);

    // 4: LastDir alternation through STOPPED
    press();
    chk_st("stop_dn_opens", OPENING);
    ticks(2);
    press();
    chk_st("opening_stop", STOPPED);
    chk_out("stopped_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    Obstruct = 1'b1;
    press();
    Obstruct = 1'b0;
    chk_st("stop_up_obstructed", STOPPED);
    press();
    chk_st("stop_up_closes", CLOSING);
    press();
    chk_st("closing_stop", STOPPED);
    press();
    chk_st("stop_dn_opens2", OPENING);
    press();
    chk_st("opening_stop2", STOPPED);
    press();
    chk_st("stop_up_closes2", CLOSING);

    // 3: closing timeout, FAULT absorbing, reset exits
    ticks(19);
    chk_st("closing_cycle20", CLOSING);
    tick();
    chk_st("closing_timeout", FAULT);
    chk_out("close_to", 1'b0, 1'b0, 1'b0, 1'b1);
    press();
    chk_st("fault_ignores_bp", FAULT);
    LimClosed = 1'b1;
    tick();
    LimClosed = 1'b0;
    chk_st("fault_ignores_lim", FAULT);
    do_reset();
    chk_st("reset_fault2", STOPPED);

    // limit beats press in STOPPED; obstructed press dropped in OPEN
    LimOpen = 1'b1;
    press();
    chk_st("stop_lim_beats_bp", OPEN);
    Obstruct = 1'b1;
    press();
    Obstruct = 1'b0;
    chk_st("open_obstructed_bp", OPEN);

    // 5: both limits in OPEN
    LimClosed = 1'b1;
    tick();
    chk_st("both_limits", FAULT);
    chk("both_limits_fault", 32'(Fault), 32'd1);
    LimOpen = 1'b0; LimClosed = 1'b0;
    do_reset();

    // limit beats press in OPENING
    LimClosed = 1'b1;
    tick();
    chk_st("closed_again", CLOSED);
    press();
    LimClosed = 1'b0;
    chk_st("opening_again", OPENING);
    LimOpen = 1'b1;
    press();
    chk_st("opening_lim_beats_bp", OPEN);

`ifndef AUTO_CLOSE_EN
    ticks(40);
    chk_st("no_auto_close", OPEN);
`else
    // 6: auto close, plain and with obstruction at expiry
    do_reset();
    tick();
    chk_st("auto_open", OPEN);
    ticks(29);
    chk_st("auto_cycle30", OPEN);
    tick();
    chk_st("auto_closing", CLOSING);
    LimOpen = 1'b0;
    do_reset();
    LimOpen = 1'b1;
    tick();
    chk_st("auto_open2", OPEN);
    ticks(29);
    Obstruct = 1'b1;
    chk_st("auto_expiry_obs", OPEN);
    tick();
    chk_st("auto_hold1", OPEN);
    tick();
    chk_st("auto_hold2", OPEN);
    Obstruct = 1'b0;
    tick();
    chk_st("auto_close_after_obs", CLOSING);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
